// File: rtl/sdr_16_port_arbiter.sv
// Round-robin arbiter sharing the SDR SDRAM command FSM between ingress FIFO ports,
// plus the periodic auto-refresh request timer.
module sdr_16_port_arbiter #(
  parameter int unsigned nr_of_ports      = 4,
  parameter int unsigned refresh_interval = 390,
  parameter int unsigned rfr_width        = 10
) (
  input  logic                   sdram_clk,
  input  logic                   sdram_rst,
  input  logic [nr_of_ports-1:0] port_empty,
  input  logic                   state_idle,
  input  logic                   fifo_rd_adr,
  input  logic                   fifo_rd_data,
  input  logic                   cmd_aref,
  output logic [nr_of_ports-1:0] fifo_sel,
  output logic                   fifo_empty,
  output logic [nr_of_ports-1:0] port_rd_adr,
  output logic [nr_of_ports-1:0] port_rd_data,
  output logic                   refresh_req,
  output logic                   refresh_overrun
);

  localparam logic [rfr_width-1:0] rfr_reload = rfr_width'(refresh_interval - 1);

  logic [nr_of_ports-1:0] fifo_sel_q, fifo_sel_d;
  logic                   served_q, served_d;
  logic                   refresh_req_q, refresh_req_d;
  logic                   overrun_q, overrun_d;
  logic [rfr_width-1:0]   rfr_cnt_q, rfr_cnt_d;

  logic        granted_empty, others_pending, rotate, rfr_zero, found;
  int unsigned gnt_idx, nxt_idx;

  assign granted_empty  = |(port_empty & fifo_sel_q);
  assign others_pending = |(~port_empty & ~fifo_sel_q);
  // A pending refresh owns the idle FSM, so the grant must not move under it.
  assign rotate         = state_idle & ~refresh_req_q & others_pending & (served_q | granted_empty);
  assign rfr_zero       = (rfr_cnt_q == '0);

  always_comb begin
    gnt_idx = 0;
    for (int unsigned j = 0; j < nr_of_ports; j++) begin
      if (fifo_sel_q[j]) gnt_idx = j;
    end
  end

  // Search upward from granted+1 with wrap; the current port is never a candidate.
  always_comb begin
    nxt_idx = gnt_idx;
    found   = 1'b0;
    for (int unsigned i = 1; i < nr_of_ports; i++) begin
      for (int unsigned j = 0; j < nr_of_ports; j++) begin
        if (!found && (j == (gnt_idx + i) % nr_of_ports) && !port_empty[j]) begin
          nxt_idx = j;
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    fifo_sel_d    = fifo_sel_q;
    served_d      = served_q;
    refresh_req_d = refresh_req_q;
    overrun_d     = overrun_q;
    rfr_cnt_d     = rfr_cnt_q - 1'b1;

    if (rotate) begin
      for (int unsigned j = 0; j < nr_of_ports; j++) begin
        fifo_sel_d[j] = (j == nxt_idx);
      end
    end

    if (rotate) begin
      served_d = 1'b0;
    end else if (fifo_rd_adr) begin
      served_d = 1'b1;
    end else if (state_idle && !others_pending) begin
      served_d = 1'b0;
    end

    if (rfr_zero) begin
      rfr_cnt_d     = rfr_reload;
      refresh_req_d = 1'b1;
      if (refresh_req_q && !cmd_aref) overrun_d = 1'b1;
    end else if (cmd_aref) begin
      refresh_req_d = 1'b0;
    end
  end

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      fifo_sel_q    <= nr_of_ports'(1);
      served_q      <= 1'b0;
      refresh_req_q <= 1'b0;
      overrun_q     <= 1'b0;
      rfr_cnt_q     <= rfr_reload;
    end else begin
      fifo_sel_q    <= fifo_sel_d;
      served_q      <= served_d;
      refresh_req_q <= refresh_req_d;
      overrun_q     <= overrun_d;
      rfr_cnt_q     <= rfr_cnt_d;
    end
  end

  assign fifo_sel        = fifo_sel_q;
  assign fifo_empty      = granted_empty | rotate;
  assign refresh_req     = refresh_req_q;
  assign refresh_overrun = overrun_q;
  // Strobes are blocked outright while reset is held.
  assign port_rd_adr  = sdram_rst ? '0 : (fifo_sel_q & {nr_of_ports{fifo_rd_adr}});
  assign port_rd_data = sdram_rst ? '0 : (fifo_sel_q & {nr_of_ports{fifo_rd_data}});

endmodule

// File: tb/tb_sdr_16_port_arbiter.sv
// Directed bench for sdr_16_port_arbiter: grant rotation, strobe steering, refresh timing,
// overrun and asynchronous reset.
module tb_sdr_16_port_arbiter;

  logic       sdram_clk = 1'b0;
  logic       sdram_rst;
  logic [3:0] port_empty;
  logic       state_idle, fifo_rd_adr, fifo_rd_data, cmd_aref;
  logic [3:0] fifo_sel, port_rd_adr, port_rd_data;
  logic       fifo_empty, refresh_req, refresh_overrun;

  int total = 0;
  int bad   = 0;

  sdr_16_port_arbiter #(
    .nr_of_ports     (4),
    .refresh_interval(390),
    .rfr_width       (10)
  ) dut (
    .sdram_clk      (sdram_clk),
    .sdram_rst      (sdram_rst),
    .port_empty     (port_empty),
    .state_idle     (state_idle),
    .fifo_rd_adr    (fifo_rd_adr),
    .fifo_rd_data   (fifo_rd_data),
    .cmd_aref       (cmd_aref),
    .fifo_sel       (fifo_sel),
    .fifo_empty     (fifo_empty),
    .port_rd_adr    (port_rd_adr),
    .port_rd_data   (port_rd_data),
    .refresh_req    (refresh_req),
    .refresh_overrun(refresh_overrun)
  );

  always #5 sdram_clk = ~sdram_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sdram_clk);
    #1;
  endtask

  // Leaves reset released 1 time unit after a rising edge, so the next edge is cycle 1.
  task automatic do_reset();
    sdram_rst    = 1'b1;
    port_empty   = 4'b1111;
    state_idle   = 1'b1;
    fifo_rd_adr  = 1'b0;
    fifo_rd_data = 1'b0;
    cmd_aref     = 1'b0;
    tick();
    tick();
    sdram_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    sdram_rst = 1'b1;
    port_empty = 4'b1111;
    state_idle = 1'b1;
    fifo_rd_adr = 1'b1;
    fifo_rd_data = 1'b1;
    cmd_aref = 1'b0;
    #3;
    total++; if (fifo_sel !== 4'b0001) begin bad++; $display("FAIL reset_sel got=%b want=0001", fifo_sel); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", fifo_empty); end
    total++; if (refresh_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", refresh_req); end
    total++; if (refresh_overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", refresh_overrun); end
    total++; if (port_rd_adr !== 4'b0000) begin bad++; $display("FAIL reset_strobe_adr got=%b want=0000", port_rd_adr); end
    total++; if (port_rd_data !== 4'b0000) begin bad++; $display("FAIL reset_strobe_data got=%b want=0000", port_rd_data); end
    do_reset();
    repeat (389) tick();
    total++; if (refresh_req !== 1'b0) begin bad++; $display("FAIL refresh_early got=%b want=0 at cycle 389", refresh_req); end
    tick();
    total++; if (refresh_req !== 1'b1) begin bad++; $display("FAIL refresh_first got=%b want=1 at cycle 390", refresh_req); end
  endtask

  task automatic test_rotate_to_port2();
    do_reset();
    port_empty = 4'b1011;
    #1;
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL rot_forced_empty got=%b want=1", fifo_empty); end
    total++; if (fifo_sel !== 4'b0001) begin bad++; $display("FAIL rot_sel_before got=%b want=0001", fifo_sel); end
    tick();
    total++; if (fifo_sel !== 4'b0100) begin bad++; $display("FAIL rot_sel_after got=%b want=0100", fifo_sel); end
    total++; if (fifo_empty !== 1'b0) begin bad++; $display("FAIL rot_empty_after got=%b want=0", fifo_empty); end
    state_idle  = 1'b0;
    fifo_rd_adr = 1'b1;
    #1;
    total++; if (port_rd_adr !== 4'b0100) begin bad++; $display("FAIL rot_rd_adr got=%b want=0100", port_rd_adr); end
    total++; if (port_rd_data !== 4'b0000) begin bad++; $display("FAIL rot_rd_data_idle got=%b want=0000", port_rd_data); end
    tick();
    fifo_rd_adr  = 1'b0;
    fifo_rd_data = 1'b1;
    #1;
    total++; if (port_rd_data !== 4'b0100) begin bad++; $display("FAIL rot_rd_data got=%b want=0100", port_rd_data); end
    total++; if (port_rd_adr !== 4'b0000) begin bad++; $display("FAIL rot_rd_adr_quiet got=%b want=0000", port_rd_adr); end
    tick();
    fifo_rd_data = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] sel0;
    logic [3:0] want;
    int n;
    do_reset();
    port_empty = 4'b0000;
    for (int t = 0; t < 8; t++) begin
      state_idle = 1'b1;
      #1;
      n = 0;
      while (fifo_empty !== 1'b0 && n < 8) begin
        tick();
        n++;
      end
      total++; if (n != ((t == 0) ? 0 : 1)) begin bad++; $display("FAIL rr_latency t=%0d got=%0d want=%0d", t, n, (t == 0) ? 0 : 1); end
      want = 4'b0001 << (t % 4);
      total++; if (fifo_sel !== want) begin bad++; $display("FAIL rr_grant t=%0d got=%b want=%b", t, fifo_sel, want); end
      sel0 = fifo_sel;
      state_idle  = 1'b0;
      fifo_rd_adr = 1'b1;
      tick();
      fifo_rd_adr  = 1'b0;
      fifo_rd_data = 1'b1;
      total++; if (fifo_sel !== sel0) begin bad++; $display("FAIL rr_stable_a t=%0d got=%b want=%b", t, fifo_sel, sel0); end
      tick();
      fifo_rd_data = 1'b0;
      total++; if (fifo_sel !== sel0) begin bad++; $display("FAIL rr_stable_b t=%0d got=%b want=%b", t, fifo_sel, sel0); end
      tick();
      total++; if (fifo_sel !== sel0) begin bad++; $display("FAIL rr_stable_c t=%0d got=%b want=%b", t, fifo_sel, sel0); end
    end
    state_idle = 1'b1;
  endtask

  task automatic test_single_active();
    do_reset();
    port_empty = 4'b1101;
    #1;
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL single_first_rotate got=%b want=1", fifo_empty); end
    tick();
    for (int t = 0; t < 3; t++) begin
      state_idle = 1'b1;
      #1;
      total++; if (fifo_empty !== 1'b0) begin bad++; $display("FAIL single_empty t=%0d got=%b want=0", t, fifo_empty); end
      total++; if (fifo_sel !== 4'b0010) begin bad++; $display("FAIL single_sel t=%0d got=%b want=0010", t, fifo_sel); end
      state_idle  = 1'b0;
      fifo_rd_adr = 1'b1;
      tick();
      fifo_rd_adr  = 1'b0;
      fifo_rd_data = 1'b1;
      tick();
      fifo_rd_data = 1'b0;
      tick();
    end
    state_idle = 1'b1;
  endtask

  task automatic test_refresh_overrun();
    do_reset();
    repeat (390) tick();
    total++; if (refresh_req !== 1'b1) begin bad++; $display("FAIL ovr_req_390 got=%b want=1", refresh_req); end
    repeat (389) tick();
    total++; if (refresh_overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b want=0 at cycle 779", refresh_overrun); end
    tick();
    total++; if (refresh_overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1 at cycle 780", refresh_overrun); end
    repeat (20) tick();
    total++; if (refresh_req !== 1'b1) begin bad++; $display("FAIL ovr_req_held got=%b want=1 at cycle 800", refresh_req); end
    cmd_aref = 1'b1;
    tick();
    cmd_aref = 1'b0;
    total++; if (refresh_req !== 1'b0) begin bad++; $display("FAIL ovr_req_ack got=%b want=0", refresh_req); end
    total++; if (refresh_overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", refresh_overrun); end
  endtask

  task automatic test_aref_collision();
    do_reset();
    repeat (389) tick();
    cmd_aref = 1'b1;
    tick();
    total++; if (refresh_req !== 1'b1) begin bad++; $display("FAIL coll_set_wins got=%b want=1", refresh_req); end
    total++; if (refresh_overrun !== 1'b0) begin bad++; $display("FAIL coll_no_ovr got=%b want=0", refresh_overrun); end
    tick();
    cmd_aref = 1'b0;
    total++; if (refresh_req !== 1'b0) begin bad++; $display("FAIL coll_ack got=%b want=0", refresh_req); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    port_empty = 4'b1011;
    tick();
    total++; if (fifo_sel !== 4'b0100) begin bad++; $display("FAIL mid_sel_pre got=%b want=0100", fifo_sel); end
    state_idle = 1'b0;
    repeat (390) tick();
    total++; if (refresh_req !== 1'b1) begin bad++; $display("FAIL mid_req_pre got=%b want=1", refresh_req); end
    fifo_rd_adr  = 1'b1;
    fifo_rd_data = 1'b1;
    #1;
    total++; if (port_rd_adr !== 4'b0100) begin bad++; $display("FAIL mid_adr_pre got=%b want=0100", port_rd_adr); end
    sdram_rst = 1'b1;
    #1;
    total++; if (fifo_sel !== 4'b0001) begin bad++; $display("FAIL mid_rst_sel got=%b want=0001", fifo_sel); end
    total++; if (refresh_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req got=%b want=0", refresh_req); end
    total++; if (port_rd_adr !== 4'b0000) begin bad++; $display("FAIL mid_rst_adr got=%b want=0000", port_rd_adr); end
    total++; if (port_rd_data !== 4'b0000) begin bad++; $display("FAIL mid_rst_data got=%b want=0000", port_rd_data); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL mid_rst_empty got=%b want=1", fifo_empty); end
    fifo_rd_adr  = 1'b0;
    fifo_rd_data = 1'b0;
    state_idle   = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rotate_to_port2();
    test_round_robin();
    test_single_active();
    test_refresh_overrun();
    test_aref_collision();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
